// File: rtl/dm_pkg.sv
// Shared types, constants and the lane-mask helper for the data-memory responder.
package dm_pkg;

   localparam int         WORD_W      = 32;
   localparam int         LANES       = 4;
   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

   typedef struct packed {
      logic              oe;
      logic [LANES-1:0]  we;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
   } dm_req_t;

   // Expands per-lane enables into a per-bit mask (lane i covers bits [8i+7:8i]).
   function automatic logic [WORD_W-1:0] lane_mask(input logic [LANES-1:0] we);
      logic [WORD_W-1:0] m;
      m = '0;
      for (int i = 0; i < LANES; i++) begin
         m[8*i +: 8] = {8{we[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Combinational byte-lane merge: enabled lanes from the new word, the rest from the old word.
module dm_lane_merge
   import dm_pkg::*;
(
   input  logic [WORD_W-1:0] old_i,
   input  logic [WORD_W-1:0] new_i,
   input  logic [LANES-1:0]  we_i,
   output logic [WORD_W-1:0] merged_o
);

   logic [WORD_W-1:0] mask;

   assign mask     = lane_mask(we_i);
   assign merged_o = (old_i & ~mask) | (new_i & mask);

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: synchronous word array with byte-lane writes, 1-cycle reads,
// out-of-range error capture and read/write access counters.
module dm_responder
   import dm_pkg::*;
#(
   parameter int          ADDR_W    = 14,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dm_output_en,
   input  logic [3:0]        dm_write_en,
   input  logic [31:0]       dm_addr,
   input  logic [31:0]       dm_data_in,
   output logic [31:0]       dm_data_out,
   output logic              err_valid,
   output logic [31:0]       err_addr,
   input  logic              err_clr,
   output logic [7:0]        err_cnt,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  wr_cnt
);

   dm_req_t           req;
   logic [ADDR_W-1:0] idx;
   logic              in_range, wr_ok, rd_ok, err_hit;
   logic [WORD_W-1:0] old_word, merged;
   logic [WORD_W-1:0] mem [2**ADDR_W];
   logic              unused_addr_lsbs;

   logic [WORD_W-1:0] dout_q, dout_d;
   logic              errv_q, errv_d;
   logic [31:0]       eaddr_q, eaddr_d;
   logic              cap_q, cap_d;
   logic [7:0]        ecnt_q, ecnt_d;
   logic [CNT_W-1:0]  rcnt_q, rcnt_d, wcnt_q, wcnt_d;

   assign req = '{oe: dm_output_en, we: dm_write_en, addr: dm_addr, wdata: dm_data_in};

   assign idx              = req.addr[ADDR_W+1:2];
   assign unused_addr_lsbs = ^req.addr[1:0];
   assign in_range         = (req.addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
   assign wr_ok            = (|req.we) && in_range;
   assign rd_ok            = req.oe && in_range;
   assign err_hit          = (req.oe || (|req.we)) && !in_range;
   assign old_word         = mem[idx];

   // One merge serves both the array update and the write-first read bypass;
   // with no lanes enabled it simply returns the stored word.
   dm_lane_merge u_merge (
      .old_i    (old_word),
      .new_i    (req.wdata),
      .we_i     (req.we),
      .merged_o (merged)
   );

   // The array is deliberately outside the reset domain so contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[idx] <= merged;
      end
   end

   always_comb begin
      dout_d  = dout_q;
      errv_d  = err_hit;
      eaddr_d = eaddr_q;
      cap_d   = cap_q;
      ecnt_d  = ecnt_q;
      rcnt_d  = rcnt_q;
      wcnt_d  = wcnt_q;

      if (req.oe) begin
         dout_d = in_range ? merged : '0;
      end
      if (rd_ok) begin
         rcnt_d = rcnt_q + CNT_W'(1);
      end
      if (wr_ok) begin
         wcnt_d = wcnt_q + CNT_W'(1);
      end

      // A clear coinciding with an error is superseded: count restarts at 1 and re-captures.
      if (err_hit) begin
         if (err_clr) begin
            ecnt_d = 8'd1;
         end else if (ecnt_q != ERR_CNT_MAX) begin
            ecnt_d = ecnt_q + 8'd1;
         end
         if (!cap_q || err_clr) begin
            eaddr_d = req.addr;
         end
         cap_d = 1'b1;
      end else if (err_clr) begin
         ecnt_d = 8'd0;
         cap_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q  <= '0;
         errv_q  <= 1'b0;
         eaddr_q <= '0;
         cap_q   <= 1'b0;
         ecnt_q  <= '0;
         rcnt_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         dout_q  <= dout_d;
         errv_q  <= errv_d;
         eaddr_q <= eaddr_d;
         cap_q   <= cap_d;
         ecnt_q  <= ecnt_d;
         rcnt_q  <= rcnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign dm_data_out = dout_q;
   assign err_valid   = errv_q;
   assign err_addr    = eaddr_q;
   assign err_cnt     = ecnt_q;
   assign rd_cnt      = rcnt_q;
   assign wr_cnt      = wcnt_q;

endmodule
